// File: rtl/truth_table_sweep_if.sv
// Bundle between the exhaustive truth-table stimulus sweeper and its user:
// stimulus/response lines plus the sweep status and error summary.
interface truth_table_sweep_if #(
   parameter int N_IN  = 4,
   parameter int N_OUT = 1
);
   logic              start;
   logic              abort;
   logic              loop;
   logic [N_IN-1:0]   vec;
   logic [N_OUT-1:0]  dut_out;
   logic [N_OUT-1:0]  exp_out;
   logic              busy;
   logic              done;
   logic [N_IN:0]     err_cnt;
   logic [N_IN-1:0]   first_err_vec;
   logic              first_err_vld;
   logic [7:0]        sweep_cnt;

   modport master (
      output start, abort, loop, dut_out, exp_out,
      input  vec, busy, done, err_cnt, first_err_vec, first_err_vld, sweep_cnt
   );

   modport slave (
      input  start, abort, loop, dut_out, exp_out,
      output vec, busy, done, err_cnt, first_err_vec, first_err_vld, sweep_cnt
   );
endinterface

// File: rtl/truth_table_sweep.sv
// Walks every input vector, holds each for DWELL cycles and compares the DUT
// response against the golden response on the last cycle of each dwell.
module truth_table_sweep #(
   parameter int N_IN  = 4,
   parameter int N_OUT = 1,
   parameter int DWELL = 100
) (
   input logic                clk,
   input logic                rst_n,
   truth_table_sweep_if.slave bus
);
   localparam int              DW         = $clog2(DWELL);
   localparam logic [DW-1:0]   DWELL_LAST = DW'(DWELL - 1);
   localparam logic [N_IN-1:0] VEC_LAST   = '1;
   localparam logic [N_IN:0]   ERR_MAX    = '1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t          state_reg;
   logic [N_IN-1:0] vec_reg;
   logic [DW-1:0]   dwell_reg;
   logic [N_IN:0]   err_cnt_reg;
   logic [N_IN-1:0] first_err_vec_reg;
   logic            first_err_vld_reg;
   logic [7:0]      sweep_cnt_reg;
   logic            loop_reg;
   logic            busy_reg;
   logic            done_reg;

   logic dwell_end;
   logic mismatch;

   assign dwell_end = (dwell_reg == DWELL_LAST);
   assign mismatch  = dwell_end && (bus.dut_out != bus.exp_out);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg         <= IDLE;
         vec_reg           <= '0;
         dwell_reg         <= '0;
         err_cnt_reg       <= '0;
         first_err_vec_reg <= '0;
         first_err_vld_reg <= 1'b0;
         sweep_cnt_reg     <= 8'd0;
         loop_reg          <= 1'b0;
         busy_reg          <= 1'b0;
         done_reg          <= 1'b0;
      end else begin
         case (state_reg)
            RUN: begin
               // The compare due on this edge is taken even when aborting.
               if (mismatch) begin
                  if (err_cnt_reg != ERR_MAX) begin
                     err_cnt_reg <= err_cnt_reg + 1'b1;
                  end
                  if (!first_err_vld_reg) begin
                     first_err_vec_reg <= vec_reg;
                     first_err_vld_reg <= 1'b1;
                  end
               end
               if (bus.abort) begin
                  state_reg <= IDLE;
                  busy_reg  <= 1'b0;
               end else if (dwell_end) begin
                  dwell_reg <= '0;
                  if (vec_reg != VEC_LAST) begin
                     vec_reg <= vec_reg + 1'b1;
                  end else begin
                     sweep_cnt_reg <= sweep_cnt_reg + 8'd1;
                     if (loop_reg) begin
                        vec_reg <= '0;
                     end else begin
                        state_reg <= DONE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                     end
                  end
               end else begin
                  dwell_reg <= dwell_reg + 1'b1;
               end
            end
            default: begin
               // IDLE and DONE: abort dominates a simultaneous start.
               if (bus.abort) begin
                  state_reg <= IDLE;
                  done_reg  <= 1'b0;
               end else if (bus.start) begin
                  state_reg         <= RUN;
                  vec_reg           <= '0;
                  dwell_reg         <= '0;
                  err_cnt_reg       <= '0;
                  first_err_vld_reg <= 1'b0;
                  sweep_cnt_reg     <= 8'd0;
                  loop_reg          <= bus.loop;
                  busy_reg          <= 1'b1;
                  done_reg          <= 1'b0;
               end
            end
         endcase
      end
   end

   assign bus.vec           = vec_reg;
   assign bus.busy          = busy_reg;
   assign bus.done          = done_reg;
   assign bus.err_cnt       = err_cnt_reg;
   assign bus.first_err_vec = first_err_vec_reg;
   assign bus.first_err_vld = first_err_vld_reg;
   assign bus.sweep_cnt     = sweep_cnt_reg;
endmodule

// File: tb/tb_truth_table_sweep.sv
// Directed scenarios for the truth-table sweeper, checked every cycle against
// an elapsed-time model of the sweep plus literal end-of-scenario values.
module tb_truth_table_sweep;
   localparam int N_IN      = 4;
   localparam int N_OUT     = 2;
   localparam int DWELL     = 4;
   localparam int NV        = 16;
   localparam int SWEEP_LEN = DWELL * NV;
   localparam int ERR_MAX   = 31;
   localparam int S_IDLE    = 0;
   localparam int S_RUN     = 1;
   localparam int S_DONE    = 2;

   logic        clk;
   logic        rst_n;
   logic [15:0] err_mask;
   int          cycle = 0;
   int          checks = 0;
   int          failures = 0;

   truth_table_sweep_if #(.N_IN(N_IN), .N_OUT(N_OUT)) bus ();

   truth_table_sweep #(.N_IN(N_IN), .N_OUT(N_OUT), .DWELL(DWELL)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Golden function plus a deliberate fault on the vectors flagged in err_mask.
   assign bus.exp_out = bus.vec[1:0] ^ bus.vec[3:2];
   assign bus.dut_out = (bus.vec[1:0] ^ bus.vec[3:2]) ^ {1'b0, err_mask[bus.vec]};

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cycle <= cycle + 1;

   function automatic void check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cycle);
      end
   endfunction

   // Model: position in the run is just elapsed RUN cycles m_t.
   int m_state, m_t, m_vec, m_err, m_fvec, m_sweep;
   bit m_fvld, m_loop;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_state = S_IDLE; m_t = 0; m_vec = 0; m_err = 0;
         m_fvec = 0; m_fvld = 0; m_sweep = 0; m_loop = 0;
      end else if (m_state == S_RUN) begin
         if ((m_t % DWELL) == DWELL - 1 && err_mask[m_vec]) begin
            m_err = (m_err < ERR_MAX) ? m_err + 1 : ERR_MAX;
            if (!m_fvld) begin
               m_fvld = 1;
               m_fvec = m_vec;
            end
         end
         if (bus.abort) begin
            m_state = S_IDLE;
         end else begin
            m_t++;
            if (m_t % SWEEP_LEN == 0) begin
               m_sweep = (m_sweep + 1) % 256;
               if (!m_loop) m_state = S_DONE;
            end
            if (m_state == S_RUN) m_vec = (m_t / DWELL) % NV;
         end
      end else if (bus.abort) begin
         m_state = S_IDLE;
      end else if (bus.start) begin
         m_state = S_RUN; m_t = 0; m_vec = 0; m_err = 0;
         m_fvld = 0; m_sweep = 0; m_loop = bus.loop;
      end
   end

   always @(negedge clk) begin
      check("vec",           int'(bus.vec),           m_vec);
      check("busy",          int'(bus.busy),          int'(m_state == S_RUN));
      check("done",          int'(bus.done),          int'(m_state == S_DONE));
      check("err_cnt",       int'(bus.err_cnt),       m_err);
      check("first_err_vec", int'(bus.first_err_vec), m_fvec);
      check("first_err_vld", int'(bus.first_err_vld), int'(m_fvld));
      check("sweep_cnt",     int'(bus.sweep_cnt),     m_sweep);
   end

   task automatic pulse_start(input bit lp);
      @(negedge clk);
      bus.start = 1'b1;
      bus.loop  = lp;
      @(negedge clk);
      bus.start = 1'b0;
      bus.loop  = 1'b0;
   endtask

   task automatic pulse_abort();
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
   endtask

   // sel: 0 = done high, 1 = vec == val, 2 = sweep_cnt == val
   task automatic wait_for(input int sel, input int val, input string name);
      bit hit = 0;
      for (int i = 0; i < 1000; i++) begin
         if ((sel == 0 && bus.done) || (sel == 1 && int'(bus.vec) == val) ||
             (sel == 2 && int'(bus.sweep_cnt) == val)) begin
            hit = 1;
            break;
         end
         @(negedge clk);
      end
      if (!hit) check({name, "_timeout"}, 0, 1);
   endtask

   int t0;

   initial begin
      rst_n = 1'b0;
      bus.start = 1'b0; bus.abort = 1'b0; bus.loop = 1'b0;
      err_mask = 16'h0000;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      check("idle_after_reset_busy", int'(bus.busy), 0);
      check("idle_after_reset_vec",  int'(bus.vec), 0);
      $display("txn reset_release: busy=%0d vec=%0d", bus.busy, bus.vec);

      // Clean single sweep
      pulse_start(1'b0);
      t0 = cycle;
      wait_for(0, 0, "clean_done");
      check("clean_latency",   cycle - t0, 64);
      check("clean_err_cnt",   int'(bus.err_cnt), 0);
      check("clean_sweep_cnt", int'(bus.sweep_cnt), 1);
      check("clean_vec",       int'(bus.vec), 15);
      $display("txn clean_sweep: cycles=%0d err_cnt=%0d sweep_cnt=%0d", cycle - t0, bus.err_cnt, bus.sweep_cnt);

      // Mismatches at vectors 5 and 11
      err_mask = 16'h0820;
      pulse_start(1'b0);
      wait_for(0, 0, "mism_done");
      check("mism_err_cnt",   int'(bus.err_cnt), 2);
      check("mism_first_vec", int'(bus.first_err_vec), 5);
      check("mism_first_vld", int'(bus.first_err_vld), 1);
      $display("txn two_mismatch: err_cnt=%0d first_err_vec=%0d", bus.err_cnt, bus.first_err_vec);

      // Abort from DONE holds results; start+abort in IDLE is ignored
      pulse_abort();
      check("done_abort_done", int'(bus.done), 0);
      check("done_abort_held", int'(bus.err_cnt), 2);
      bus.start = 1'b1; bus.abort = 1'b1;
      @(negedge clk);
      bus.start = 1'b0; bus.abort = 1'b0;
      @(negedge clk);
      check("start_abort_busy", int'(bus.busy), 0);
      $display("txn start_and_abort_idle: busy=%0d done=%0d", bus.busy, bus.done);

      // Start during RUN is ignored
      err_mask = 16'h0000;
      pulse_start(1'b0);
      t0 = cycle;
      wait_for(1, 3, "restart_vec3");
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      wait_for(0, 0, "restart_done");
      check("restart_latency", cycle - t0, 64);
      check("restart_vec",     int'(bus.vec), 15);
      $display("txn start_in_run: cycles=%0d vec=%0d", cycle - t0, bus.vec);

      // Looping, abort at dwell end in the fourth sweep: that compare still counts
      err_mask = 16'h0002;
      pulse_start(1'b1);
      t0 = cycle;
      wait_for(2, 1, "loop_sweep1");
      check("loop_sweep1_time", cycle - t0, 64);
      wait_for(2, 3, "loop_sweep3");
      wait_for(1, 1, "loop_vec1");
      repeat (3) @(negedge clk);
      pulse_abort();
      check("loop_abort_busy",  int'(bus.busy), 0);
      check("loop_abort_sweep", int'(bus.sweep_cnt), 3);
      check("loop_abort_err",   int'(bus.err_cnt), 4);
      repeat (5) @(negedge clk);
      check("loop_vec_frozen",  int'(bus.vec), 1);
      $display("txn loop_abort: sweep_cnt=%0d err_cnt=%0d vec=%0d", bus.sweep_cnt, bus.err_cnt, bus.vec);

      // Every vector mismatches: counter saturates
      err_mask = 16'hFFFF;
      pulse_start(1'b1);
      wait_for(2, 2, "sat_sweep2");
      check("sat_err_2", int'(bus.err_cnt), ERR_MAX);
      wait_for(2, 3, "sat_sweep3");
      check("sat_err_3",     int'(bus.err_cnt), ERR_MAX);
      check("sat_first_vec", int'(bus.first_err_vec), 0);
      pulse_abort();
      $display("txn saturation: err_cnt=%0d", bus.err_cnt);

      // Asynchronous reset mid-dwell at vec 9
      err_mask = 16'h0004;
      pulse_start(1'b0);
      wait_for(1, 9, "rst_vec9");
      @(negedge clk);
      check("pre_rst_err", int'(bus.err_cnt), 1);
      #2 rst_n = 1'b0;
      #1;
      check("rst_vec",   int'(bus.vec), 0);
      check("rst_busy",  int'(bus.busy), 0);
      check("rst_err",   int'(bus.err_cnt), 0);
      check("rst_fvec",  int'(bus.first_err_vec), 0);
      check("rst_fvld",  int'(bus.first_err_vld), 0);
      check("rst_sweep", int'(bus.sweep_cnt), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      check("post_rst_vec",  int'(bus.vec), 0);
      check("post_rst_busy", int'(bus.busy), 0);
      $display("txn async_reset: vec=%0d busy=%0d", bus.vec, bus.busy);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
